// File: rtl/console_mmio_ctrl_pkg.sv
// Shared constants and types for the memory-mapped console controller.
package console_mmio_ctrl_pkg;

   localparam logic [31:0] CONSOLE_ADDR        = 32'h0000_FFFC;
   localparam logic [31:0] CONSOLE_STATUS_ADDR = 32'h0000_FFF8;
   localparam int          CONSOLE_FLUSH_BIT   = 8;
   localparam int          CONSOLE_DEPTH       = 8;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } console_state_t;

   // Layout of the read-only status word seen by console loads.
   function automatic logic [31:0] status_word(input logic [7:0] count,
                                               input logic       full,
                                               input logic       empty);
      return {16'h0000, count, 6'b00_0000, full, empty};
   endfunction

endpackage

// File: rtl/console_mmio_ctrl_fifo.sv
// First-word fall-through FIFO buffering console characters.
module console_fifo
   import console_mmio_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = CONSOLE_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s, do_pop_s;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == {CW{1'b0}});
   assign count = count_q;
   assign rdata = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_push_s = push && (!full || do_pop_s);
   assign do_pop_s  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array carries no reset; the read port is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/console_mmio_ctrl.sv
// Console controller on the core data port: char capture, flush handshake,
// overflow stall and a read-only status word.
module console_mmio_ctrl
   import console_mmio_ctrl_pkg::*;
#(
   parameter logic [31:0] CONSOLE_ADDR_P = CONSOLE_ADDR,
   parameter logic [31:0] STATUS_ADDR    = CONSOLE_STATUS_ADDR,
   parameter int          DEPTH          = CONSOLE_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic        stall,
   output logic        status_hit,
   output logic [31:0] status_rdata,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   console_state_t state_q, state_d;

   logic          hit_s;
   logic          flush_req_s;
   logic          push_s;
   logic          pop_s;
   logic          stall_full_s;
   logic          full_s;
   logic          empty_s;
   logic [CW-1:0] count_s;
   logic          unused_wdata_s;

   assign hit_s          = memwrite && (dataadr == CONSOLE_ADDR_P);
   assign flush_req_s    = writedata[CONSOLE_FLUSH_BIT];
   assign unused_wdata_s = ^writedata[31:9];

   assign tx_valid     = !empty_s;
   assign pop_s        = tx_valid && tx_ready;
   // tx_ready feeds stall combinationally so a full FIFO can trade a pop for a push.
   assign stall_full_s = hit_s && full_s && !pop_s;
   assign push_s       = hit_s && !stall_full_s && (state_q == RUN) && !flush_req_s;
   assign stall        = stall_full_s || (state_q == FLUSH);

   assign status_hit   = !memwrite && (dataadr == STATUS_ADDR);
   assign status_rdata = status_word(8'(count_s), full_s, empty_s);

   console_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (writedata[7:0]),
      .rdata (tx_data),
      .full  (full_s),
      .empty (empty_s),
      .count (count_s)
   );

   // DONE releases the core for one cycle so the flush store retires without re-arming.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (hit_s && flush_req_s) begin
               state_d = FLUSH;
            end else begin
               state_d = RUN;
            end
         end
         FLUSH: begin
            if (count_s == {CW{1'b0}}) begin
               state_d = DONE;
            end else begin
               state_d = FLUSH;
            end
         end
         DONE:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_console_mmio_ctrl.sv
// Directed self-checking bench for console_mmio_ctrl.
module tb_console_mmio_ctrl;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        stall;
   logic        status_hit;
   logic [31:0] status_rdata;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   int checks;
   int errors;

   console_mmio_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .memwrite     (memwrite),
      .dataadr      (dataadr),
      .writedata    (writedata),
      .stall        (stall),
      .status_hit   (status_hit),
      .status_rdata (status_rdata),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic mw, input logic [31:0] adr,
                        input logic [31:0] wd, input logic rdy);
      memwrite  = mw;
      dataadr   = adr;
      writedata = wd;
      tx_ready  = rdy;
   endtask

   task automatic test_reset;
      #22;
      reset = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || stall !== 1'b0 || status_rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL reset_assert: tx_valid=%b stall=%b status=%h required 0 0 00000001",
                  tx_valid, stall, status_rdata);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, 32'h0000_FFFC, 32'h0000_0055, 1'b1);
         #1;
         checks++;
         if (tx_valid !== 1'b0 || stall !== 1'b0 || status_rdata !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reset_hold: tx_valid=%b stall=%b status=%h required 0 0 00000001",
                     tx_valid, stall, status_rdata);
         end
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      reset = 1'b1;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || stall !== 1'b0 || status_rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL reset_release: tx_valid=%b stall=%b status=%h required 0 0 00000001",
                  tx_valid, stall, status_rdata);
      end
   endtask

   task automatic test_single_char;
      @(negedge clk);
      drive(1'b1, 32'h0000_FFFC, 32'h0000_0041, 1'b1);
      #1;
      checks++;
      if (tx_valid !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL single_pre: tx_valid=%b stall=%b required 0 0", tx_valid, stall);
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h41 || status_rdata !== 32'h0000_0100) begin
         errors++;
         $display("FAIL single_visible: tx_valid=%b tx_data=%h status=%h required 1 41 00000100",
                  tx_valid, tx_data, status_rdata);
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      checks++;
      if (tx_valid !== 1'b0 || status_rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL single_drained: tx_valid=%b status=%h required 0 00000001",
                  tx_valid, status_rdata);
      end
   endtask

   task automatic test_overflow;
      logic [7:0] ch;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ch = 8'h61 + 8'(i);
         drive(1'b1, 32'h0000_FFFC, {24'h0, ch}, 1'b0);
         #1;
         checks++;
         if (stall !== 1'b0) begin
            errors++;
            $display("FAIL overflow_fill[%0d]: stall=%b required 0", i, stall);
         end
      end
      @(negedge clk);
      drive(1'b1, 32'h0000_FFFC, 32'h0000_0069, 1'b0);
      #1;
      checks++;
      if (stall !== 1'b1 || status_rdata !== 32'h0000_0802 || tx_data !== 8'h61) begin
         errors++;
         $display("FAIL overflow_stall: stall=%b status=%h tx_data=%h required 1 00000802 61",
                  stall, status_rdata, tx_data);
      end
      @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b1 || status_rdata !== 32'h0000_0802) begin
         errors++;
         $display("FAIL overflow_held: stall=%b status=%h required 1 00000802", stall, status_rdata);
      end
      tx_ready = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || tx_data !== 8'h61) begin
         errors++;
         $display("FAIL overflow_swap: stall=%b tx_data=%h required 0 61", stall, tx_data);
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      checks++;
      if (status_rdata !== 32'h0000_0802 || tx_data !== 8'h62) begin
         errors++;
         $display("FAIL overflow_after_swap: status=%h tx_data=%h required 00000802 62",
                  status_rdata, tx_data);
      end
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         tx_ready = 1'b1;
         ch = 8'h62 + 8'(j);
         #1;
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== ch) begin
            errors++;
            $display("FAIL overflow_drain[%0d]: tx_valid=%b tx_data=%h required 1 %h",
                     j, tx_valid, tx_data, ch);
         end
      end
      @(negedge clk);
      tx_ready = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || status_rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL overflow_empty: tx_valid=%b status=%h required 0 00000001",
                  tx_valid, status_rdata);
      end
   endtask

   task automatic test_flush;
      logic       exp_stall, exp_valid, rdy;
      logic [7:0] exp_data;
      int         pops;
      pops = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, 32'h0000_FFFC, 32'h0000_0078 + 32'(i), 1'b0);
      end
      @(negedge clk);
      drive(1'b1, 32'h0000_FFFC, 32'h0000_0100, 1'b0);
      #1;
      checks++;
      if (stall !== 1'b0 || status_rdata !== 32'h0000_0300) begin
         errors++;
         $display("FAIL flush_request: stall=%b status=%h required 0 00000300", stall, status_rdata);
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         rdy = (k % 2 == 0);
         tx_ready = rdy;
         exp_stall = (k < 8);
         exp_valid = (k <= 6);
         exp_data  = 8'h78 + 8'((k - 1) / 2);
         #1;
         checks++;
         if (stall !== exp_stall || tx_valid !== exp_valid ||
             (exp_valid && tx_data !== exp_data)) begin
            errors++;
            $display("FAIL flush_cycle[%0d]: stall=%b tx_valid=%b tx_data=%h required %b %b %h",
                     k, stall, tx_valid, tx_data, exp_stall, exp_valid, exp_data);
         end
         if (tx_valid && rdy) pops++;
      end
      checks++;
      if (pops != 3) begin
         errors++;
         $display("FAIL flush_pops: got %0d required 3", pops);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(1'b0, 32'h0, 32'h0, 1'b1);
         #1;
         checks++;
         if (stall !== 1'b0 || tx_valid !== 1'b0 || status_rdata !== 32'h0000_0001) begin
            errors++;
            $display("FAIL flush_after[%0d]: stall=%b tx_valid=%b status=%h required 0 0 00000001",
                     k, stall, tx_valid, status_rdata);
         end
      end
   endtask

   task automatic test_decode;
      @(negedge clk);
      drive(1'b1, 32'h0000_FFF8, 32'h0000_0055, 1'b1);
      #1;
      checks++;
      if (stall !== 1'b0 || status_hit !== 1'b0) begin
         errors++;
         $display("FAIL decode_store_status: stall=%b status_hit=%b required 0 0", stall, status_hit);
      end
      @(negedge clk);
      drive(1'b0, 32'h0000_FFF8, 32'h0000_0000, 1'b1);
      #1;
      checks++;
      if (tx_valid !== 1'b0 || status_hit !== 1'b1 || stall !== 1'b0 ||
          status_rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL decode_load_status: tx_valid=%b status_hit=%b stall=%b status=%h required 0 1 0 00000001",
                  tx_valid, status_hit, stall, status_rdata);
      end
      @(negedge clk);
      drive(1'b0, 32'h0000_FFFC, 32'h0000_0042, 1'b1);
      #1;
      checks++;
      if (status_hit !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL decode_load_console: status_hit=%b stall=%b required 0 0", status_hit, stall);
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      checks++;
      if (tx_valid !== 1'b0 || status_rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL decode_no_push: tx_valid=%b status=%h required 0 00000001",
                  tx_valid, status_rdata);
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(1'b1, 32'h0000_FFFC, 32'h0000_0030 + 32'(i), 1'b0);
      end
      @(negedge clk);
      drive(1'b1, 32'h0000_FFFC, 32'h0000_0100, 1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b1 || status_rdata !== 32'h0000_0500) begin
         errors++;
         $display("FAIL midreset_flushing: stall=%b status=%h required 1 00000500", stall, status_rdata);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || tx_valid !== 1'b0 || status_rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL midreset_async: stall=%b tx_valid=%b status=%h required 0 0 00000001",
                  stall, tx_valid, status_rdata);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || tx_valid !== 1'b0 || status_rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL midreset_release: stall=%b tx_valid=%b status=%h required 0 0 00000001",
                  stall, tx_valid, status_rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0 || tx_valid !== 1'b0 || status_rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL midreset_settled: stall=%b tx_valid=%b status=%h required 0 0 00000001",
                  stall, tx_valid, status_rdata);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      test_reset();
      test_single_char();
      test_overflow();
      test_flush();
      test_decode();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
